// File: rtl/pu_demultiplexer_pkg.sv
// Shared definitions for pu_demultiplexer.
//   state_t          : controller state encoding (3 bits)
//   ATTR_INVALID_BIT : attribute bit that flags an invalid bus value
package pu_demultiplexer_pkg;

  typedef enum logic [2:0] {
    S_EMPTY = 3'd0,  // nothing loaded
    S_SEL   = 3'd1,  // selector loaded, waiting for data
    S_DATA  = 3'd2,  // data loaded, waiting for selector
    S_FULL  = 3'd3,  // both loaded, no slot emitted yet
    S_DRAIN = 3'd4   // emitting slots 1..NOUT-1
  } state_t;

  localparam int ATTR_INVALID_BIT = 0;

endpackage

// File: rtl/pu_demultiplexer.sv
// pu_demultiplexer: routes one data word to one of 2**SEL_WIDTH output slots.
// A selector and a data word are loaded from the shared bus (either order).
// The slots are then read out one per out_active strobe in order 0..NOUT-1.
// The selected slot carries the data word and every other slot carries 0.
// Ports:
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   data_active : latch data_in as the data word
//   sel_active  : latch data_in as the selector (wins over data_active)
//   out_active  : read strobe; emit current slot and advance
//   data_in     : signed bus input
//   attr_in     : unused
//   data_out    : signed slot value (0 when out_active is low)
//   attr_out    : bit 0 = invalid flag, other bits always 0
module pu_demultiplexer
  import pu_demultiplexer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4,
  parameter int SEL_WIDTH  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_active,
  input  logic                  sel_active,
  input  logic                  out_active,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ATTR_WIDTH-1:0] attr_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ATTR_WIDTH-1:0] attr_out
);

  localparam int NOUT = 2**SEL_WIDTH;
  localparam logic [SEL_WIDTH:0] LAST_IDX = (SEL_WIDTH+1)'(NOUT-1);
  localparam logic signed [DATA_WIDTH-1:0] MAX_SEL = DATA_WIDTH'(NOUT-1);

  logic [DATA_WIDTH-1:0] r_data;
  logic [SEL_WIDTH-1:0]  r_sel;
  logic                  r_sel_oor;
  logic [SEL_WIDTH:0]    r_rd_idx;
  state_t                r_state;

  state_t                w_state_next;
  logic [SEL_WIDTH:0]    w_rd_idx_next;
  logic                  w_ld_sel;
  logic                  w_ld_data;
  logic                  w_ld_any;
  logic                  w_oor;
  logic [SEL_WIDTH:0]    w_slot;
  logic                  w_hit;
  logic                  w_drainable;
  logic signed [DATA_WIDTH-1:0] w_din_s;
  logic                  w_unused_attr;

  assign w_unused_attr = ^attr_in;

  // A selector strobe drops a simultaneous data strobe.
  assign w_ld_sel  = sel_active;
  assign w_ld_data = data_active & ~sel_active;
  assign w_ld_any  = w_ld_sel | w_ld_data;

  // Range check uses the whole signed bus word, not just the low selector bits.
  assign w_din_s = data_in;
  assign w_oor   = w_din_s[DATA_WIDTH-1] | (w_din_s > MAX_SEL);

  // In S_FULL the counter has not moved yet, so the slot being emitted is 0.
  assign w_slot      = (r_state == S_FULL) ? '0 : r_rd_idx;
  assign w_hit       = (w_slot == {1'b0, r_sel}) & ~r_sel_oor;
  assign w_drainable = (r_state == S_FULL) | (r_state == S_DRAIN);

  always_comb begin
    data_out = '0;
    attr_out = '0;
    if (out_active) begin
      if (w_drainable) begin
        data_out                   = w_hit ? r_data : '0;
        attr_out[ATTR_INVALID_BIT] = r_sel_oor;
      end else begin
        attr_out[ATTR_INVALID_BIT] = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_rd_idx_next = r_rd_idx;
    unique case (r_state)
      S_EMPTY: begin
        if (w_ld_sel)       w_state_next = S_SEL;
        else if (w_ld_data) w_state_next = S_DATA;
      end
      S_SEL: begin
        if (w_ld_data) w_state_next = S_FULL;
      end
      S_DATA: begin
        if (w_ld_sel) w_state_next = S_FULL;
      end
      S_FULL: begin
        // A load alone just re-latches; a load together with a read
        // starts a fresh transaction after slot 0 has been emitted.
        if (out_active && w_ld_any) begin
          w_state_next  = w_ld_sel ? S_SEL : S_DATA;
          w_rd_idx_next = '0;
        end else if (out_active) begin
          w_state_next  = S_DRAIN;
          w_rd_idx_next = (SEL_WIDTH+1)'(1);
        end
      end
      S_DRAIN: begin
        if (w_ld_any) begin
          w_state_next  = w_ld_sel ? S_SEL : S_DATA;
          w_rd_idx_next = '0;
        end else if (out_active) begin
          if (r_rd_idx == LAST_IDX) begin
            w_state_next  = S_EMPTY;
            w_rd_idx_next = '0;
          end else begin
            w_rd_idx_next = r_rd_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_next  = S_EMPTY;
        w_rd_idx_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_EMPTY;
      r_rd_idx  <= '0;
      r_data    <= '0;
      r_sel     <= '0;
      r_sel_oor <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_rd_idx <= w_rd_idx_next;
      if (w_ld_sel) begin
        r_sel     <= data_in[SEL_WIDTH-1:0];
        r_sel_oor <= w_oor;
      end
      if (w_ld_data) begin
        r_data <= data_in;
      end
    end
  end

endmodule
